// File: rtl/mby_msh_rsp_pkg.sv
// Shared types for the mesh-side memory responder.
//   msh_op_e   : request/response opcode (read or write)
//   msh_rsp_t  : one response beat {op, tag, data, err}, sized for the default widths
//   MSH_CNT_W  : width of the saturating read/write statistics counters
package mby_msh_rsp_pkg;

  typedef enum logic {
    MSH_RD = 1'b0,
    MSH_WR = 1'b1
  } msh_op_e;

  localparam int MSH_ADDR_W = 12;
  localparam int MSH_DATA_W = 64;
  localparam int MSH_TAG_W  = 8;
  localparam int MSH_CNT_W  = 32;

  typedef struct packed {
    msh_op_e               op;
    logic [MSH_TAG_W-1:0]  tag;
    logic [MSH_DATA_W-1:0] data;
    logic                  err;
  } msh_rsp_t;

endpackage

// File: rtl/mby_msh_mem_responder_if.sv
// GMM-to-mesh request/response bundle plus responder status.
//   master : GMM side; drives req_* and rsp_ready, observes the rest
//   slave  : responder side; drives req_ready, rsp_*, outstanding, rd_cnt, wr_cnt
interface mby_msh_mem_responder_if #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int RSP_DEPTH = 4
);
  localparam int OUT_W = $clog2(RSP_DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_op;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [OUT_W-1:0]                         outstanding;
  logic [mby_msh_rsp_pkg::MSH_CNT_W-1:0]    rd_cnt;
  logic [mby_msh_rsp_pkg::MSH_CNT_W-1:0]    wr_cnt;

  modport master (
    output req_valid, req_op, req_addr, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_op, rsp_tag, rsp_data, rsp_err,
           outstanding, rd_cnt, wr_cnt
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_op, rsp_tag, rsp_data, rsp_err,
           outstanding, rd_cnt, wr_cnt
  );

endinterface

// File: rtl/mby_msh_rsp_fifo.sv
// Synchronous valid/ready FIFO with a registered output stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : write side; in_data captured when both are high
//   out_valid/out_ready : read side; out_data is a flop and holds while stalled
// When the output register is free and the buffer is empty, a push lands
// directly in the output register so the beat is visible the next cycle.
module mby_msh_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             load, bypass, buf_push, buf_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (cnt_q < CNT_W'(DEPTH));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    load     = !out_valid_q || out_ready;
    buf_pop  = load && (cnt_q != '0);
    bypass   = load && (cnt_q == '0) && in_valid;
    buf_push = in_valid && in_ready && !bypass;

    rd_ptr_d = buf_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = buf_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    cnt_d = cnt_q;
    if (buf_push && !buf_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!buf_push && buf_pop) cnt_d = cnt_q - CNT_W'(1);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (buf_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = buf_q[rd_ptr_q];
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (buf_push) buf_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/mby_msh_mem_responder.sv
// Mesh-side responder terminating the GMM-to-mesh request interface.
// Reads and writes are serviced against a local array at the accept edge and
// the response travels an RD_LAT-deep pipeline into an in-order response FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : req_* in / req_ready out, rsp_* out / rsp_ready in,
//                outstanding, rd_cnt, wr_cnt status outputs
module mby_msh_mem_responder
  import mby_msh_rsp_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mby_msh_mem_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OUT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    msh_op_e           op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  function automatic logic [MSH_CNT_W-1:0] sat_inc(input logic [MSH_CNT_W-1:0] v,
                                                   input logic en);
    logic [MSH_CNT_W-1:0] r;
    r = v;
    if (en && (v != '1)) r = v + MSH_CNT_W'(1);
    return r;
  endfunction

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]     written_q, written_d;
  rsp_t                 pipe_q [RD_LAT];
  rsp_t                 pipe_d [RD_LAT];
  logic [RD_LAT-1:0]    vld_q, vld_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic [MSH_CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic                 accept, in_range, is_rd, is_wr, rsp_hs;
  logic                 fifo_in_rdy, push;
  logic [IDX_W-1:0]     idx;
  rsp_t                 req_rsp, fifo_out;

  // Ready depends only on the registered occupancy, never on rsp_ready.
  assign bus.req_ready = (outstanding_q < OUT_W'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  // Extra MSB keeps the range check correct when DEPTH == 2**ADDR_W.
  assign in_range      = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx           = bus.req_addr[IDX_W-1:0];
  assign is_rd         = accept && (msh_op_e'(bus.req_op) == MSH_RD);
  assign is_wr         = accept && (msh_op_e'(bus.req_op) == MSH_WR);
  assign rsp_hs        = bus.rsp_valid && bus.rsp_ready;

  // Stage 0: build the response from the array contents seen at the accept edge.
  always_comb begin
    req_rsp     = '0;
    req_rsp.op  = msh_op_e'(bus.req_op);
    req_rsp.tag = bus.req_tag;
    req_rsp.err = !in_range;
    if (is_rd && in_range && written_q[idx]) req_rsp.data = mem_q[idx];
  end

  always_comb begin
    vld_d[0]  = accept;
    pipe_d[0] = req_rsp;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    written_d = written_q;
    if (is_wr && in_range) written_d[idx] = 1'b1;

    outstanding_d = outstanding_q;
    if (accept && !rsp_hs)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!accept && rsp_hs) outstanding_d = outstanding_q - OUT_W'(1);

    rd_cnt_d = sat_inc(rd_cnt_q, is_rd);
    wr_cnt_d = sat_inc(wr_cnt_q, is_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q         <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      written_q     <= '0;
      outstanding_q <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
    end else begin
      vld_q         <= vld_d;
      pipe_q        <= pipe_d;
      written_q     <= written_d;
      outstanding_q <= outstanding_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  // Storage contents are deliberately left unreset; the written bits gate reads.
  always_ff @(posedge clk) begin
    if (is_wr && in_range) mem_q[idx] <= bus.req_data;
  end

  // Stage RD_LAT: hand off to the response FIFO. The outstanding limit keeps
  // the FIFO from filling, so fifo_in_rdy is always high here.
  assign push = vld_q[RD_LAT-1] && fifo_in_rdy;

  mby_msh_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push),
    .in_ready  (fifo_in_rdy),
    .in_data   (pipe_q[RD_LAT-1]),
    .out_valid (bus.rsp_valid),
    .out_ready (bus.rsp_ready),
    .out_data  (fifo_out)
  );

  assign bus.rsp_op      = fifo_out.op;
  assign bus.rsp_tag     = fifo_out.tag;
  assign bus.rsp_data    = fifo_out.data;
  assign bus.rsp_err     = fifo_out.err;
  assign bus.outstanding = outstanding_q;
  assign bus.rd_cnt      = rd_cnt_q;
  assign bus.wr_cnt      = wr_cnt_q;

endmodule
